// File: rtl/motor_pkg.sv
// Shared motor-control types and default constants, common to the command stage and the PWM stage.
package motor_pkg;

    localparam int unsigned DUTY_W      = 32;
    localparam int unsigned DUTY_MAX    = 1_800_000;
    localparam int unsigned DUTY_STEP   = 200_000;
    localparam int unsigned DUTY_PERIOD = 2_000_000;

    typedef enum logic [1:0] {
        RUN,
        DECEL,
        DEAD,
        SWAP
    } motor_state_e;

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button conditioning: 2-FF synchronizer, debounce filter, and a one-cycle pulse on each accepted press.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counting only while the synced level differs from the accepted one makes any
    // bounce back to the old level restart the qualification window.
    always_comb begin
        cnt_d       = '0;
        stable_d    = stable_q;
        press_pulse = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d    = sync2_q;
                press_pulse = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_speed_ctrl.sv
// Motor command stage: button conditioning, saturating setpoint, duty ramp and safe direction reversal.
// Define MOTOR_SPEED_CTRL_DEADTIME_EN to hold both bridge inputs low for DEAD_CYCLES before a direction swap.
module motor_speed_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned DUTY_MAX        = motor_pkg::DUTY_MAX,
    parameter int unsigned DUTY_STEP       = motor_pkg::DUTY_STEP,
    parameter int unsigned RAMP_DIV        = 10_000,
    parameter int unsigned RAMP_INC        = 2_000,
    parameter int unsigned DEAD_CYCLES     = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_dir,
    output logic [31:0] duty_cmd,
    output logic [31:0] setpoint,
    output logic        direction1,
    output logic        direction2,
    output logic        reversing
);

    import motor_pkg::*;

    localparam logic [DUTY_W-1:0] DMAX     = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DSTEP    = DUTY_W'(DUTY_STEP);
    localparam logic [DUTY_W-1:0] DINC     = DUTY_W'(RAMP_INC);
    localparam logic [DUTY_W-1:0] UP_LIMIT = DUTY_W'(DUTY_MAX - DUTY_STEP);
    localparam int unsigned       DIV_W    = $clog2(RAMP_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);

    logic up_pulse;
    logic down_pulse;
    logic dir_pulse;

    motor_state_e      state_q, state_d;
    logic [DUTY_W-1:0] setpoint_q, setpoint_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              dir_q, dir_d;
    logic              ramp_tick;
    logic [DUTY_W-1:0] target;
    logic              bridge_off;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
        .clk(clk), .reset(reset), .btn_raw(btn_up), .press_pulse(up_pulse)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
        .clk(clk), .reset(reset), .btn_raw(btn_down), .press_pulse(down_pulse)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dir (
        .clk(clk), .reset(reset), .btn_raw(btn_dir), .press_pulse(dir_pulse)
    );

    // Limits are tested before the add/subtract so the 32-bit value can never wrap.
    always_comb begin
        setpoint_d = setpoint_q;
        if (up_pulse && !down_pulse) begin
            setpoint_d = (setpoint_q >= UP_LIMIT) ? DMAX : setpoint_q + DSTEP;
        end else if (down_pulse && !up_pulse) begin
            setpoint_d = (setpoint_q <= DSTEP) ? '0 : setpoint_q - DSTEP;
        end
    end

    always_comb begin
        ramp_tick = (div_q == DIV_LAST);
        div_d     = ramp_tick ? '0 : div_q + DIV_W'(1);
        target    = (state_q == RUN) ? setpoint_q : '0;
        duty_d    = duty_q;
        if (ramp_tick) begin
            if (duty_q < target) begin
                duty_d = (target - duty_q <= DINC) ? target : duty_q + DINC;
            end else if (duty_q > target) begin
                duty_d = (duty_q - target <= DINC) ? target : duty_q - DINC;
            end
        end
    end

`ifdef MOTOR_SPEED_CTRL_DEADTIME_EN
    localparam int unsigned      DEAD_W    = $clog2(DEAD_CYCLES + 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            dead_cnt_q <= '0;
        end else begin
            dead_cnt_q <= dead_cnt_d;
        end
    end

    assign bridge_off = (state_q == DEAD);
`else
    // The dead-time length only matters when the DEAD state is compiled in.
    logic unused_dead_cycles;
    assign unused_dead_cycles = ^DEAD_CYCLES;
    assign bridge_off         = 1'b0;
`endif

    // The direction flips on entry to SWAP, so SWAP already drives the new polarity.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
`ifdef MOTOR_SPEED_CTRL_DEADTIME_EN
        dead_cnt_d = '0;
`endif
        case (state_q)
            RUN: begin
                if (dir_pulse) begin
                    state_d = DECEL;
                end
            end
            DECEL: begin
                if (duty_q == '0) begin
`ifdef MOTOR_SPEED_CTRL_DEADTIME_EN
                    state_d = DEAD;
`else
                    state_d = SWAP;
                    dir_d   = ~dir_q;
`endif
                end
            end
`ifdef MOTOR_SPEED_CTRL_DEADTIME_EN
            DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d = SWAP;
                    dir_d   = ~dir_q;
                end else begin
                    dead_cnt_d = dead_cnt_q + DEAD_W'(1);
                end
            end
`endif
            SWAP: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            setpoint_q <= '0;
            duty_q     <= '0;
            div_q      <= '0;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            setpoint_q <= setpoint_d;
            duty_q     <= duty_d;
            div_q      <= div_d;
            dir_q      <= dir_d;
        end
    end

    assign duty_cmd   = duty_q;
    assign setpoint   = setpoint_q;
    assign direction1 = dir_q & ~bridge_off;
    assign direction2 = ~dir_q & ~bridge_off;
    assign reversing  = (state_q != RUN);

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Self-checking bench for motor_speed_ctrl: directed scenarios plus randomized button activity against a behavioural model.
module tb_motor_speed_ctrl;

    localparam int DEB   = 4;
    localparam int RDIV  = 2;
    localparam int RINC  = 50_000;
    localparam int DEADC = 8;
    localparam int DMAX  = 1_800_000;
    localparam int DSTEP = 200_000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_dir = 1'b0;
    logic [31:0] duty_cmd;
    logic [31:0] setpoint;
    logic        direction1;
    logic        direction2;
    logic        reversing;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int both_low_cycles = 0;

    always #5 clk = ~clk;

    motor_speed_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .DUTY_MAX(DMAX),
        .DUTY_STEP(DSTEP),
        .RAMP_DIV(RDIV),
        .RAMP_INC(RINC),
        .DEAD_CYCLES(DEADC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_dir(btn_dir),
        .duty_cmd(duty_cmd),
        .setpoint(setpoint),
        .direction1(direction1),
        .direction2(direction2),
        .reversing(reversing)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_duty, m_set, m_edges, m_dead_left;
    bit m_dir, m_rev, m_decel;
    bit m_stable[3];
    bit hist[3][DEB+2];

    function automatic void model_reset();
        m_duty = 0; m_set = 0; m_edges = 0; m_dead_left = 0;
        m_dir = 1'b0; m_rev = 1'b0; m_decel = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_stable[b] = 1'b0;
            for (int i = 0; i < DEB + 2; i++) hist[b][i] = 1'b0;
        end
    endfunction

    // A press is accepted once the level seen two synchronizer stages late has been high DEB samples running.
    function automatic bit filt(input int b, input bit raw);
        bit all_hi, all_lo;
        all_hi = 1'b1;
        all_lo = 1'b1;
        for (int i = DEB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = raw;
        for (int i = 2; i <= DEB + 1; i++) begin
            all_hi = all_hi & hist[b][i];
            all_lo = all_lo & !hist[b][i];
        end
        if (all_hi && !m_stable[b]) begin
            m_stable[b] = 1'b1;
            return 1'b1;
        end
        if (all_lo) m_stable[b] = 1'b0;
        return 1'b0;
    endfunction

    initial model_reset();

    always @(posedge clk) begin : model_step
        bit p_up, p_dn, p_dir;
        int target, nset, nduty;
        if (reset) begin
            model_reset();
        end else begin
            p_up  = filt(0, btn_up);
            p_dn  = filt(1, btn_down);
            p_dir = filt(2, btn_dir);

            nset = m_set;
            if (p_up && !p_dn)      nset = (m_set + DSTEP > DMAX) ? DMAX : m_set + DSTEP;
            else if (p_dn && !p_up) nset = (m_set < DSTEP) ? 0 : m_set - DSTEP;

            m_edges++;
            nduty = m_duty;
            if (m_edges % RDIV == 0) begin
                target = m_rev ? 0 : m_set;
                if (m_duty < target)      nduty = (target - m_duty < RINC) ? target : m_duty + RINC;
                else if (m_duty > target) nduty = (m_duty - target < RINC) ? target : m_duty - RINC;
            end

            if (!m_rev) begin
                if (p_dir) begin
                    m_rev = 1'b1;
                    m_decel = 1'b1;
                end
            end else if (m_decel) begin
                if (m_duty == 0) begin
                    m_decel = 1'b0;
`ifdef MOTOR_SPEED_CTRL_DEADTIME_EN
                    m_dead_left = DEADC;
`else
                    m_dir = !m_dir;
`endif
                end
            end else if (m_dead_left > 0) begin
                if (m_dead_left == 1) m_dir = !m_dir;
                m_dead_left--;
            end else begin
                m_rev = 1'b0;
            end

            m_set  = nset;
            m_duty = nduty;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit in_dead;
        if (chk_en) begin
            in_dead = (m_dead_left > 0);
            check("duty_cmd", duty_cmd, m_duty);
            check("setpoint", setpoint, m_set);
            check("direction1", direction1, in_dead ? 0 : m_dir);
            check("direction2", direction2, in_dead ? 0 : !m_dir);
            check("reversing", reversing, m_rev);
            check("bridge_not_both_high", direction1 & direction2, 0);
`ifndef MOTOR_SPEED_CTRL_DEADTIME_EN
            check("bridge_not_both_low", direction1 | direction2, 1);
`endif
            if (!direction1 && !direction2) both_low_cycles++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_up = v;
            1: btn_down = v;
            default: btn_dir = v;
        endcase
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b, input int hold, input int gap);
        set_btn(b, 1'b1);
        cycles(hold);
        set_btn(b, 1'b0);
        cycles(gap);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_duty"}, duty_cmd, 0);
        check({tag, "_setpoint"}, setpoint, 0);
        check({tag, "_dir1"}, direction1, 0);
        check({tag, "_dir2"}, direction2, 1);
        check({tag, "_reversing"}, reversing, 0);
    endtask

    initial begin : stim
        bit found;
        reset = 1'b1;
        cycles(3);
        chk_en = 1'b1;
        check_reset_values("reset");
        reset = 1'b0;
        cycles(2);

        // Clean press: accepted exactly 2+DEB edges after the raw edge.
        btn_up = 1'b1;
        cycles(5);
        check("press_latency_before", setpoint, 0);
        cycles(1);
        check("press_latency_at", setpoint, 200_000);
        cycles(4);
        btn_up = 1'b0;
        cycles(20);
        check("clean_press_setpoint", setpoint, 200_000);
        check("clean_press_duty", duty_cmd, 200_000);

        // Bounce: only the final held level counts.
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            cycles(2);
        end
        press(0, 10, 30);
        check("bounce_setpoint", setpoint, 400_000);
        check("bounce_duty", duty_cmd, 400_000);

        // Reversal from 400_000 with a second dir press and an up press during DECEL.
        both_low_cycles = 0;
        press(2, 6, 0);
        check("rev_started", reversing, 1);
        cycles(6);
        btn_dir = 1'b1;
        btn_up  = 1'b1;
        cycles(6);
        btn_dir = 1'b0;
        btn_up  = 1'b0;
        check("rev_up_during_decel", setpoint, 600_000);
        cycles(120);
        check("rev_dir1", direction1, 1);
        check("rev_dir2", direction2, 0);
        check("rev_done", reversing, 0);
        check("rev_duty_restored", duty_cmd, 600_000);
`ifdef MOTOR_SPEED_CTRL_DEADTIME_EN
        check("dead_cycles", both_low_cycles, DEADC);
`else
        check("dead_cycles", both_low_cycles, 0);
`endif

        // Saturation at both ends, then simultaneous up+down.
        for (int i = 0; i < 10; i++) press(0, 6, 6);
        check("sat_high", setpoint, 1_800_000);
        for (int i = 0; i < 12; i++) press(1, 6, 6);
        check("sat_low", setpoint, 0);
        press(0, 6, 6);
        btn_up = 1'b1;
        btn_down = 1'b1;
        cycles(8);
        btn_up = 1'b0;
        btn_down = 1'b0;
        cycles(8);
        check("up_down_same_cycle", setpoint, 200_000);

        // Reset in the middle of a reversal.
        press(0, 6, 30);
        btn_dir = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
`ifdef MOTOR_SPEED_CTRL_DEADTIME_EN
            found = (!direction1 && !direction2);
`else
            found = reversing;
`endif
        end
        check("mid_reversal_reached", found, 1);
        btn_dir = 1'b0;
        reset = 1'b1;
        cycles(1);
        check_reset_values("mid_rev_reset");
        reset = 1'b0;
        cycles(4);

        // Randomized button activity with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 7) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 9) == 0) btn_dir = ~btn_dir;
            reset = ($urandom_range(0, 299) == 0);
            cycles(1);
        end
        reset = 1'b0;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_speed_ctrl.md
Name: motor_speed_ctrl

Overview:
- Upstream command stage for the PWM motor driver.
- Conditions the three raw push-buttons (speed up, slow down, direction) and maintains a saturating duty setpoint.
- Ramps the output duty toward that setpoint and sequences direction reversal safely: decelerate to zero, swap, re-accelerate.
- Outputs feed the PWM generator's duty compare and the H-bridge direction pins.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, stable-input cycles (10 ms @ 100 MHz) before a button level is accepted.
- DUTY_MAX, 1_800_000, setpoint ceiling in clk counts.
- DUTY_STEP, 200_000, setpoint change per accepted up/down press.
- RAMP_DIV, 10_000, clk cycles between ramp increments.
- RAMP_INC, 2_000, maximum duty_cmd change per ramp tick.
- DEAD_CYCLES, 100_000, bridge-off time during reversal (only with DEADTIME_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- btn_up  in  1  raw asynchronous speed-up button.
- btn_down  in  1  raw asynchronous slow-down button.
- btn_dir  in  1  raw asynchronous direction button.
- duty_cmd  out  32  ramped duty to the PWM compare; range 0..DUTY_MAX.
- setpoint  out  32  current target duty.
- direction1  out  1  H-bridge input A.
- direction2  out  1  H-bridge input B.
- reversing  out  1  high while a reversal is in progress.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: duty_cmd=0, setpoint=0, direction1=0, direction2=1, reversing=0, FSM=RUN, ramp divider=0, debounce state cleared (stable level 0).
- Button conditioning, per button:
  - 2-FF synchronizer, then debounce counter.
  - Counter resets on any change of the synced level; the stable level updates when the counter reaches DEBOUNCE_CYCLES-1.
  - A one-cycle press pulse is emitted on the stable 0->1 transition.
  - Latency from raw edge to pulse: 2 + DEBOUNCE_CYCLES cycles.
- Setpoint update:
  - up pulse: setpoint = min(setpoint+DUTY_STEP, DUTY_MAX).
  - down pulse: setpoint = max(setpoint-DUTY_STEP, 0), with no unsigned underflow.
  - up and down pulses in the same cycle: no change.
  - Updates are accepted in every FSM state.
- Ramp:
  - Divider counts 0..RAMP_DIV-1; on wrap, duty_cmd moves toward the effective target by at most RAMP_INC, clamped exactly at the target with no overshoot.
  - Effective target = setpoint in RUN, 0 in DECEL/DEAD/SWAP.
  - The divider free-runs and is not reset by state changes.
- FSM (RUN, DECEL, DEAD, SWAP):
  - RUN: dir pulse -> DECEL, reversing=1.
  - DECEL: when duty_cmd==0 -> DEAD (with DEADTIME_EN) or SWAP (without). A dir pulse here is ignored.
  - DEAD: direction1=direction2=0 for DEAD_CYCLES, then -> SWAP.
  - SWAP: one cycle. The previous direction is inverted (saved before DEAD); outputs are restored inverted. -> RUN, reversing=0.
  - A dir pulse in DEAD or SWAP is ignored.
  - A dir pulse with duty_cmd already 0 still passes through DECEL for 1 cycle.
- direction1 and direction2 are never both 1.
- Reset mid-reversal returns to the reset values; no partial swap is retained.
- Arithmetic: 32-bit unsigned. Saturation compares are done before add/subtract.

Optional Feature:
- Macro: MOTOR_SPEED_CTRL_DEADTIME_EN.
- Defined: DEAD state present; both bridge inputs are held low for DEAD_CYCLES before the direction swap.
- Undefined: DEAD state and its counter are not compiled; DECEL goes directly to SWAP, and both bridge inputs are never simultaneously low after reset.

Decomposition:
- Shared package motor_pkg:
  - state enum {RUN, DECEL, DEAD, SWAP}.
  - DUTY_W=32.
  - Default constants DUTY_MAX, DUTY_STEP, DUTY_PERIOD=2_000_000, shared with the PWM stage.
- Sub-module button_conditioner (sync + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, RAMP_DIV=2, RAMP_INC=50_000, DEAD_CYCLES=8):
- Clean press: btn_up held 10 cycles -> exactly one pulse; setpoint=200_000 after 2+4 cycles. duty_cmd reaches 200_000 after 4 ramp ticks (8 cycles) and holds.
- Bounce: btn_up toggled every 2 cycles for 20 cycles, then held -> only one setpoint increment.
- Saturation: 10 up presses -> setpoint=1_800_000. 12 down presses -> setpoint=0, not wrapped. Simultaneous up+down pulses -> unchanged.
- Reversal at duty_cmd=400_000:
  - dir press -> reversing=1; duty_cmd ramps to 0.
  - (with DEADTIME_EN) direction1=direction2=0 for 8 cycles.
  - Then direction1=1, direction2=0; reversing=0; duty_cmd ramps back to 400_000.
- Presses during reversal: second dir press during DECEL ignored. An up press during DECEL raises setpoint to 600_000, applied after RUN resumes.
- Reset asserted in DEAD -> next cycle: duty_cmd=0, setpoint=0, direction1=0, direction2=1, reversing=0.
